// File: rtl/qsp_instr_encoder.sv
// qsp_instr_encoder
//   Packs field-level QSP instruction requests into 32-bit words (SI / SR / C
//   formats) and buffers them in a small FIFO whose head feeds the decoder's
//   instruction input. Illegal opcodes and out-of-range immediates are
//   rejected (handshake still completes) and reported via pulses + sticky bits.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     request handshake
//   in_op, in_rd, in_rs1,
//   in_rs2, in_imm          request fields (op_t opcode, regs, signed imm)
//   out_valid / out_ready   word handshake, out_instr = FIFO head (0 if empty)
//   count                   occupied FIFO entries, 0..DEPTH
//   flush                   empty the FIFO on the next edge
//   err_illegal, err_imm    1-cycle rejection pulses
//   err_sticky              {imm, illegal} sticky flags, cleared by err_clr
//
// Opcode map (op_t):
//   SI : ADD_IMM 01, SHL_IMM 02, SHR_IMM 03, LCSET_IMM 04, SUB_IMM 05,
//        CMP_IMM 06, MOV_IMM 07
//   SR : ADD_REG 11, SHL_REG 12, SHR_REG 13, SUB_REG 15, CMP_REG 16, MOV_REG 17
//   C  : NOP 00, BRANCH 20, LOOP 21, HALT 22, YIELD 23
//   All other codes are illegal.
module qsp_instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [5:0]                 in_op,
   input  logic [3:0]                 in_rd,
   input  logic [3:0]                 in_rs1,
   input  logic [3:0]                 in_rs2,
   input  logic [31:0]                in_imm,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       flush,
   output logic                       err_illegal,
   output logic                       err_imm,
   output logic [1:0]                 err_sticky,
   input  logic                       err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {CLS_ILL, CLS_SI, CLS_SR, CLS_C} cls_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_reg;

   cls_t          cls;
   logic          imm_ok;
   logic [31:0]   word;
   logic          accept;
   logic          push;
   logic          pop;
   logic          ill_hit;
   logic          imm_hit;

   always_comb begin
      cls = CLS_ILL;
      case (in_op)
         6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: cls = CLS_SI;
         6'h11, 6'h12, 6'h13, 6'h15, 6'h16, 6'h17:        cls = CLS_SR;
         6'h00, 6'h20, 6'h21, 6'h22, 6'h23:               cls = CLS_C;
         default:                                         cls = CLS_ILL;
      endcase
   end

   // Fits signed 18-bit iff the top 15 bits are a pure sign extension of bit 17.
   assign imm_ok = (&in_imm[31:17]) | ~(|in_imm[31:17]);

   always_comb begin
      word = '0;
      case (cls)
         CLS_SI:  word = {in_op, in_rd, in_rs1, in_imm[17:0]};
         CLS_SR:  word = {in_op, in_rd, in_rs1, in_rs2, 14'h0};
         CLS_C:   word = {in_op, 4'h0, in_rs1, in_imm[17:0]};
         default: word = '0;
      endcase
   end

   assign in_ready  = rst_n & (count_reg != FULL) & ~flush;
   assign out_valid = (count_reg != '0);
   assign out_instr = out_valid ? mem[rd_ptr] : '0;
   assign count     = count_reg;

   assign accept  = in_valid & in_ready;
   assign ill_hit = accept & (cls == CLS_ILL);
   // SR words carry no immediate, so only SI/C can fail the range check.
   assign imm_hit = accept & ((cls == CLS_SI) | (cls == CLS_C)) & ~imm_ok;
   assign push    = accept & ~ill_hit & ~imm_hit;
   assign pop     = out_valid & out_ready & ~flush;

   // Storage has no reset; emptiness is tracked by count and out_instr is
   // masked while empty, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_reg   <= '0;
         err_illegal <= 1'b0;
         err_imm     <= 1'b0;
         err_sticky  <= 2'b00;
      end else begin
         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_reg <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
         end
         err_illegal <= ill_hit;
         err_imm     <= imm_hit;
         // A new pulse overrides a simultaneous clear.
         err_sticky  <= (err_clr ? 2'b00 : err_sticky) | {imm_hit, ill_hit};
      end
   end

endmodule

// File: tb/tb_qsp_instr_encoder.sv
module tb_qsp_instr_encoder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_op;
   logic [3:0]  in_rd;
   logic [3:0]  in_rs1;
   logic [3:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [2:0]  count;
   logic        flush;
   logic        err_illegal;
   logic        err_imm;
   logic [1:0]  err_sticky;
   logic        err_clr;

   int checks = 0;
   int passes = 0;

   // reference model state
   logic [31:0] mq[$];
   logic        m_ill;
   logic        m_imm;
   logic [1:0]  m_sticky;

   qsp_instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .count(count), .flush(flush),
      .err_illegal(err_illegal), .err_imm(err_imm),
      .err_sticky(err_sticky), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // 0 = illegal, 1 = SI, 2 = SR, 3 = C
   function automatic int op_class(input logic [5:0] op);
      int v = int'(op);
      if (v >= 1 && v <= 7) return 1;
      if (v == 17 || v == 18 || v == 19 || v == 21 || v == 22 || v == 23) return 2;
      if (v == 0 || (v >= 32 && v <= 35)) return 3;
      return 0;
   endfunction

   function automatic bit imm_in_range(input logic [31:0] imm);
      int s = int'($signed(imm));
      return (s >= -131072) && (s <= 131071);
   endfunction

   function automatic logic [31:0] encode(input int c, input logic [5:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2,
                                          input logic [31:0] imm);
      logic [31:0] w = 32'(op) * 32'h0400_0000 + 32'(rs1) * 32'h0004_0000;
      if (c == 1) w = w + 32'(rd) * 32'h0040_0000 + (imm % 32'h0004_0000);
      if (c == 2) w = w + 32'(rd) * 32'h0040_0000 + 32'(rs2) * 32'h0000_4000;
      if (c == 3) w = w + (imm % 32'h0004_0000);
      return w;
   endfunction

   task automatic idle();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
      in_op = 6'h00; in_rd = 4'h0; in_rs1 = 4'h0; in_rs2 = 4'h0; in_imm = 32'h0;
   endtask

   task automatic req(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [31:0] imm);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
   endtask

   // Advance one clock edge; the model consumes the same inputs the DUT sees.
   task automatic cycle();
      bit rdy, pil, pim;
      int c;
      @(posedge clk);
      pil = 1'b0; pim = 1'b0;
      if (!rst_n) begin
         mq.delete();
         m_sticky = 2'b00;
      end else begin
         rdy = (mq.size() < DEPTH) && !flush;
         if (flush) mq.delete();
         else if (out_ready && mq.size() > 0) void'(mq.pop_front());
         if (in_valid && rdy) begin
            c = op_class(in_op);
            if (c == 0) begin
               pil = 1'b1;
               $display("txn reject-illegal op=%02h", in_op);
            end else if (c != 2 && !imm_in_range(in_imm)) begin
               pim = 1'b1;
               $display("txn reject-imm op=%02h imm=%08h", in_op, in_imm);
            end else begin
               mq.push_back(encode(c, in_op, in_rd, in_rs1, in_rs2, in_imm));
               $display("txn push op=%02h word=%08h", in_op, mq[$]);
            end
         end
         m_sticky = (err_clr ? 2'b00 : m_sticky) | {pim, pil};
      end
      m_ill = pil;
      m_imm = pim;
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      cycle();
      cycle();
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", out_valid); else passes++;
      checks++; if (count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", count); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low got=%0b exp=0", in_ready); else passes++;
      checks++; if (out_instr !== 32'h0) $display("FAIL rst_instr got=%08h exp=0", out_instr); else passes++;
      checks++; if ({err_illegal, err_imm, err_sticky} !== 4'b0) $display("FAIL rst_err got=%04b exp=0000", {err_illegal, err_imm, err_sticky}); else passes++;
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_high got=%0b exp=1", in_ready); else passes++;
   endtask

   task automatic test_encode();
      logic [31:0] exp;
      req(6'h01, 4'h3, 4'h5, 4'h9, 32'hFFFF_FFFF);
      cycle();
      in_valid = 1'b0;
      exp = {6'h01, 4'h3, 4'h5, 18'h3FFFF};
      checks++; if (out_valid !== 1'b1) $display("FAIL si_valid got=%0b exp=1", out_valid); else passes++;
      checks++; if (out_instr !== exp) $display("FAIL si_word got=%08h exp=%08h", out_instr, exp); else passes++;
      checks++; if (count !== 3'd1) $display("FAIL si_count got=%0d exp=1", count); else passes++;
      out_ready = 1'b1; cycle(); out_ready = 1'b0;

      req(6'h15, 4'h1, 4'h2, 4'h7, 32'hDEAD_BEEF);
      cycle();
      in_valid = 1'b0;
      exp = {6'h15, 4'h1, 4'h2, 4'h7, 14'h0};
      checks++; if (out_instr !== exp) $display("FAIL sr_word got=%08h exp=%08h", out_instr, exp); else passes++;
      checks++; if ({err_illegal, err_imm} !== 2'b00) $display("FAIL sr_noerr got=%02b exp=00", {err_illegal, err_imm}); else passes++;
      out_ready = 1'b1; cycle(); out_ready = 1'b0;

      req(6'h07, 4'h2, 4'h4, 4'h0, 32'd131072);
      cycle();
      in_valid = 1'b0;
      checks++; if (count !== 3'd0) $display("FAIL imm_nopush got=%0d exp=0", count); else passes++;
      checks++; if ({err_imm, err_illegal} !== 2'b10) $display("FAIL imm_pulse got=%02b exp=10", {err_imm, err_illegal}); else passes++;
      checks++; if (err_sticky !== 2'b10) $display("FAIL imm_sticky got=%02b exp=10", err_sticky); else passes++;
      cycle();
      checks++; if (err_imm !== 1'b0) $display("FAIL imm_one_cycle got=%0b exp=0", err_imm); else passes++;

      req(6'h07, 4'h0, 4'h0, 4'h0, -32'sd131072);
      cycle();
      in_valid = 1'b0;
      exp = {6'h07, 4'h0, 4'h0, 18'h20000};
      checks++; if (out_instr !== exp) $display("FAIL imm_min_word got=%08h exp=%08h", out_instr, exp); else passes++;
      out_ready = 1'b1; cycle(); out_ready = 1'b0;

      // C class forces rd to zero
      req(6'h20, 4'hF, 4'hA, 4'h3, 32'h0000_1234);
      cycle();
      in_valid = 1'b0;
      exp = {6'h20, 4'h0, 4'hA, 18'h01234};
      checks++; if (out_instr !== exp) $display("FAIL c_word got=%08h exp=%08h", out_instr, exp); else passes++;
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [31:0] exp;
      for (int i = 0; i < DEPTH; i++) begin
         req(6'h00, 4'hF, 4'(i + 1), 4'h0, 32'(i + 16));
         cycle();
      end
      checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%0b exp=0", in_ready); else passes++;
      checks++; if (count !== 3'd4) $display("FAIL full_count got=%0d exp=4", count); else passes++;
      req(6'h01, 4'h1, 4'h1, 4'h0, 32'h5);
      cycle();
      checks++; if (count !== 3'd4) $display("FAIL full_held got=%0d exp=4", count); else passes++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         exp = {6'h00, 4'h0, 4'(i + 1), 18'(i + 16)};
         checks++; if (out_instr !== exp) $display("FAIL drain_word%0d got=%08h exp=%08h", i, out_instr, exp); else passes++;
         cycle();
      end
      out_ready = 1'b0;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL drain_empty count=%0d valid=%0b exp=0/0", count, out_valid); else passes++;
   endtask

   task automatic test_illegal();
      req(6'h3F, 4'h1, 4'h1, 4'h1, 32'h7FFF_FFFF);
      cycle();
      in_valid = 1'b0;
      checks++; if ({err_illegal, err_imm} !== 2'b10) $display("FAIL ill_pulse got=%02b exp=10", {err_illegal, err_imm}); else passes++;
      checks++; if (count !== 3'd0) $display("FAIL ill_count got=%0d exp=0", count); else passes++;
      checks++; if (err_sticky !== 2'b11) $display("FAIL ill_sticky got=%02b exp=11", err_sticky); else passes++;
      req(6'h3F, 4'h0, 4'h0, 4'h0, 32'h0);
      err_clr = 1'b1;
      cycle();
      in_valid = 1'b0; err_clr = 1'b0;
      checks++; if (err_sticky !== 2'b01) $display("FAIL clr_vs_pulse got=%02b exp=01", err_sticky); else passes++;
      err_clr = 1'b1; cycle(); err_clr = 1'b0;
      checks++; if (err_sticky !== 2'b00) $display("FAIL clr_only got=%02b exp=00", err_sticky); else passes++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         req(6'h11, 4'(i), 4'(i), 4'(i), 32'h0);
         cycle();
      end
      in_valid = 1'b1;
      flush = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0b exp=0", in_ready); else passes++;
      cycle();
      idle();
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL flush_empty count=%0d valid=%0b exp=0/0", count, out_valid); else passes++;
      checks++; if (out_instr !== 32'h0) $display("FAIL flush_instr got=%08h exp=0", out_instr); else passes++;
   endtask

   task automatic test_mid_reset();
      req(6'h02, 4'h1, 4'h2, 4'h0, 32'h1);
      cycle();
      req(6'h3F, 4'h0, 4'h0, 4'h0, 32'h0);
      cycle();
      in_valid = 1'b1;
      rst_n = 1'b0;
      cycle();
      checks++; if ({out_valid, count, in_ready} !== 5'b0) $display("FAIL mrst_state got=%05b exp=00000", {out_valid, count, in_ready}); else passes++;
      checks++; if ({err_illegal, err_imm, err_sticky} !== 4'b0 || out_instr !== 32'h0) $display("FAIL mrst_err got=%04b instr=%08h exp=0", {err_illegal, err_imm, err_sticky}, out_instr); else passes++;
      rst_n = 1'b1;
      idle();
      cycle();
   endtask

   task automatic test_random();
      int bnd[4] = '{131071, 131072, -131072, -131073};
      logic [31:0] exp_instr;
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(0, 99) >= 2);
         in_valid  = ($urandom_range(0, 99) < 70);
         in_op     = 6'($urandom_range(0, 63));
         in_rd     = 4'($urandom);
         in_rs1    = 4'($urandom);
         in_rs2    = 4'($urandom);
         case ($urandom_range(0, 3))
            0: in_imm = 32'($urandom_range(0, 262143) - 131072);
            1: in_imm = 32'(bnd[$urandom_range(0, 3)]);
            2: in_imm = $urandom;
            default: in_imm = 32'($urandom_range(0, 255));
         endcase
         out_ready = ($urandom_range(0, 99) < 50);
         flush     = ($urandom_range(0, 99) < 5);
         err_clr   = ($urandom_range(0, 99) < 10);
         #1;
         checks++; if (in_ready !== (rst_n && mq.size() < DEPTH && !flush)) $display("FAIL rnd_in_ready n=%0d got=%0b exp=%0b", n, in_ready, (rst_n && mq.size() < DEPTH && !flush)); else passes++;
         cycle();
         exp_instr = (mq.size() > 0) ? mq[0] : 32'h0;
         checks++; if (out_valid !== (mq.size() > 0) || count !== 3'(mq.size())) $display("FAIL rnd_occ n=%0d valid=%0b count=%0d exp_count=%0d", n, out_valid, count, mq.size()); else passes++;
         checks++; if (out_instr !== exp_instr) $display("FAIL rnd_instr n=%0d got=%08h exp=%08h", n, out_instr, exp_instr); else passes++;
         checks++; if ({err_illegal, err_imm, err_sticky} !== {m_ill, m_imm, m_sticky}) $display("FAIL rnd_err n=%0d got=%04b exp=%04b", n, {err_illegal, err_imm, err_sticky}, {m_ill, m_imm, m_sticky}); else passes++;
      end
      idle();
      rst_n = 1'b1;
   endtask

   initial begin
      m_ill = 1'b0; m_imm = 1'b0; m_sticky = 2'b00;
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_encode();
      test_fill_drain();
      test_illegal();
      test_flush();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
